// File: rtl/function_generator_playback_sequencer.sv
// function_generator_playback_sequencer: waveform RAM read-address sequencer with loop/one-shot playback and delayed sync.
// Defining PLAYBACK_REPEAT_COUNT_EN adds a repeat_count input that stops loop playback after that many passes.
module function_generator_playback_sequencer #(
  parameter int ADDR_WIDTH = 14,
  parameter int SYNC_DELAY = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  trigger,
  input  logic                  resync,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-1:0] end_address,
`ifdef PLAYBACK_REPEAT_COUNT_EN
  input  logic [15:0]           repeat_count,
`endif
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  running,
  output logic                  sync_out,
  output logic                  done,
  output logic                  config_error
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] addr_one = 1;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n, end_l, end_n;
  logic [SYNC_DELAY-1:0] sync_pipe;
  logic one_shot, one_shot_n, sync_raw, done_n, trig_q, valid, wrap, rise, load;
`ifdef PLAYBACK_REPEAT_COUNT_EN
  logic [15:0] reps, reps_n, passes, passes_n;
  logic halt, halt_n;
`endif
  assign running = state == RUN;
  assign sync_out = sync_pipe[SYNC_DELAY-1];
  always_comb begin
    valid = end_address > start_address;
    wrap = read_address == end_l - addr_one;
    rise = trigger && !trig_q;
    state_n = state;
    addr_n = read_address;
    end_n = end_l;
    one_shot_n = one_shot;
    done_n = 1'b0;
    load = 1'b0;
`ifdef PLAYBACK_REPEAT_COUNT_EN
    reps_n = reps;
    passes_n = passes;
    halt_n = halt && enable;
`endif
    if (!enable) begin
      state_n = IDLE;
      addr_n = start_address;
    end else begin
      case (state)
        IDLE: begin
          addr_n = start_address;
`ifdef PLAYBACK_REPEAT_COUNT_EN
          if (valid && !halt) begin
            reps_n = repeat_count;
            passes_n = 16'd0;
`else
          if (valid) begin
`endif
            state_n = mode ? ARMED : RUN;
            one_shot_n = 1'b0;
            load = !mode;
          end
        end
        ARMED: begin
          addr_n = start_address;
          if (rise) begin
            state_n = valid ? RUN : IDLE;
            one_shot_n = 1'b1;
            load = valid;
          end
        end
        default: begin
          addr_n = read_address + addr_one;
          if (wrap && one_shot) begin
            state_n = ARMED;
            addr_n = start_address;
            done_n = 1'b1;
          end else if (wrap || resync) begin
            // A reload re-validates the live window; an invalid one drops back to IDLE.
            addr_n = start_address;
            state_n = valid ? RUN : IDLE;
            load = valid;
`ifdef PLAYBACK_REPEAT_COUNT_EN
            if (wrap) begin
              passes_n = passes + 16'd1;
              if (reps != 16'd0 && passes_n == reps) begin
                state_n = IDLE;
                load = 1'b0;
                done_n = 1'b1;
                halt_n = 1'b1;
              end
            end
`endif
          end
        end
      endcase
    end
    if (load) begin
      end_n = end_address;
      addr_n = start_address;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      read_address <= '0;
      end_l <= '0;
      one_shot <= 1'b0;
      sync_raw <= 1'b0;
      sync_pipe <= '0;
      done <= 1'b0;
      config_error <= 1'b0;
      trig_q <= 1'b0;
`ifdef PLAYBACK_REPEAT_COUNT_EN
      reps <= '0;
      passes <= '0;
      halt <= 1'b0;
`endif
    end else begin
      state <= state_n;
      read_address <= addr_n;
      end_l <= end_n;
      one_shot <= one_shot_n;
      sync_raw <= load;
      sync_pipe <= SYNC_DELAY'({sync_pipe, sync_raw});
      done <= done_n;
      config_error <= enable && !valid;
      trig_q <= trigger;
`ifdef PLAYBACK_REPEAT_COUNT_EN
      reps <= reps_n;
      passes <= passes_n;
      halt <= halt_n;
`endif
    end
  end
endmodule

// File: tb/tb_function_generator_playback_sequencer.sv
// tb_function_generator_playback_sequencer: directed and randomized checks against a pass-position reference model.
module tb_function_generator_playback_sequencer;
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, mode = 1'b0, trigger = 1'b0, resync = 1'b0;
  logic [13:0] start_address = '0, end_address = '0;
  logic [13:0] read_address;
  logic running, sync_out, done, config_error;
  int errors = 0, checks = 0;
  int ph, lo, hi, pos, m_addr;
  bit oneshot, trig_prev, m_run, m_sync, m_done, m_cfg;
  bit sq[$];

  function_generator_playback_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .trigger(trigger), .resync(resync),
    .start_address(start_address), .end_address(end_address),
`ifdef PLAYBACK_REPEAT_COUNT_EN
    .repeat_count(16'd0),
`endif
    .read_address(read_address), .running(running), .sync_out(sync_out), .done(done),
    .config_error(config_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ph = 0; m_addr = 0; lo = 0; hi = 0; pos = 0; oneshot = 0; trig_prev = 0;
    m_run = 0; m_sync = 0; m_done = 0; m_cfg = 0;
    sq = '{0, 0, 0};
  endfunction

  // ph: 0 idle, 1 waiting for trigger, 2 playing position pos of window [lo,hi)
  function automatic void model_step();
    bit valid = end_address > start_address;
    bit rise = trigger && !trig_prev;
    bit restart = 0;
    bit last = ph == 2 && lo + pos == hi - 1;
    m_done = 0;
    if (!enable) begin
      ph = 0; m_addr = start_address;
    end else if (ph == 0) begin
      m_addr = start_address;
      if (valid) begin
        if (mode) ph = 1;
        else begin oneshot = 0; restart = 1; end
      end
    end else if (ph == 1) begin
      m_addr = start_address;
      if (rise) begin
        if (valid) begin oneshot = 1; restart = 1; end
        else ph = 0;
      end
    end else if (last && oneshot) begin
      ph = 1; m_done = 1; m_addr = start_address;
    end else if (last || resync) begin
      if (valid) restart = 1;
      else begin ph = 0; m_addr = start_address; end
    end else begin
      pos++; m_addr = lo + pos;
    end
    if (restart) begin
      ph = 2; lo = start_address; hi = end_address; pos = 0; m_addr = lo;
    end
    m_cfg = enable && !valid;
    trig_prev = trigger;
    sq.push_back(restart);
    m_sync = sq.pop_front();
    m_run = ph == 2;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("read_address", read_address, m_addr);
    chk("running", running, m_run);
    chk("sync_out", sync_out, m_sync);
    chk("done", done, m_done);
    chk("config_error", config_error, m_cfg);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int a);
    for (int i = 0; i < 400 && m_addr != a; i++) tick();
    chk("reach_address", read_address, a);
  endtask

  task automatic set_win(input int s, input int e);
    start_address = 14'(s); end_address = 14'(e);
  endtask

  task automatic pulse_resync();
    resync = 1'b1; tick(); resync = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    chk("reset_addr", read_address, 0);
    chk("reset_running", running, 0);
    chk("reset_sync", sync_out, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg", config_error, 0);
    reset = 1'b0;
    // loop 16..20
    set_win(16, 20); enable = 1'b1; ticks(14);
    enable = 1'b0; tick();
    // one-shot 0..4, held trigger must not rerun
    set_win(0, 4); mode = 1'b1; enable = 1'b1; ticks(3);
    trigger = 1'b1; ticks(10);
    trigger = 1'b0; tick(); trigger = 1'b1; ticks(7);
    enable = 1'b0; mode = 1'b0; trigger = 1'b0; tick();
    // invalid window then fixed
    set_win(8, 8); enable = 1'b1; ticks(3);
    chk("cfg_err_set", config_error, 1);
    set_win(8, 12); ticks(6);
    // length-1 window
    set_win(5, 6); ticks(6);
    // resync mid-pass and at last address
    set_win(0, 100); ticks(1);
    run_to(50); pulse_resync(); ticks(4);
    run_to(99); pulse_resync(); ticks(5);
    // one-shot with resync on the last address
    enable = 1'b0; tick();
    set_win(20, 24); mode = 1'b1; enable = 1'b1; ticks(2);
    trigger = 1'b1; tick(); trigger = 1'b0;
    run_to(23); pulse_resync(); ticks(5);
    enable = 1'b0; mode = 1'b0; tick();
    // top-of-range window
    set_win(16380, 16383); enable = 1'b1; ticks(10);
    // async reset mid-pass
    set_win(0, 100); ticks(1);
    run_to(37);
    #2 reset = 1'b1;
    #1 chk("async_addr", read_address, 0);
    chk("async_running", running, 0);
    chk("async_sync", sync_out, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    ticks(8);
    // randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) set_win($urandom_range(0, 12), $urandom_range(0, 16));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) trigger = ~trigger;
      resync = $urandom_range(0, 19) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
